// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default line/clock
// constants used by both the RX and TX paths.
package uart_pkg;

   localparam int unsigned DEF_SYS_CLK    = 100_000_000;
   localparam int unsigned DEF_BAUD       = 9600;
   localparam int unsigned DEF_OVERSAMPLE = 16;
   localparam int unsigned DEF_DATA_BITS  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   // Clocks per oversample tick (integer division, truncating).
   function automatic int unsigned tick_count(input int unsigned sys_clk,
                                              input int unsigned baud,
                                              input int unsigned oversample);
      return sys_clk / (baud * oversample);
   endfunction

endpackage

// File: rtl/uart_rx_os_tick.sv
// Free-running oversample tick generator: one-clock os_tick every TICK_COUNT
// clocks, same counter semantics as the TX baud tick generator.
module uart_rx_os_tick
   import uart_pkg::*;
#(
   parameter int unsigned SYS_CLK    = DEF_SYS_CLK,
   parameter int unsigned BAUD       = DEF_BAUD,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic clk,
   input  logic rst,
   output logic os_tick
);

   localparam int unsigned TICK_COUNT = tick_count(SYS_CLK, BAUD, OVERSAMPLE);
   localparam int unsigned CW         = $clog2(TICK_COUNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_COUNT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign os_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling: synchronizes rx, detects the start
// edge, samples each bit at its centre and reports the byte or a framing error.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned SYS_CLK    = DEF_SYS_CLK,
   parameter int unsigned BAUD       = DEF_BAUD,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned DATA_BITS  = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 rx_busy,
   output logic                 frame_err
);

   localparam int unsigned SCW = $clog2(OVERSAMPLE);
   localparam int unsigned BIW = $clog2(DATA_BITS) + 1;
   localparam logic [SCW-1:0] SC_HALF = SCW'(OVERSAMPLE / 2 - 1);
   localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
   localparam logic [BIW-1:0] BI_LAST = BIW'(DATA_BITS - 1);

   rx_state_t            state;
   logic                 os_tick;
   logic                 rx_m, rx_s, rx_d;
   logic                 fall;
   logic [SCW-1:0]       sc;
   logic [BIW-1:0]       bit_idx;
   logic [DATA_BITS-1:0] shreg;

   uart_rx_os_tick #(
      .SYS_CLK    (SYS_CLK),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_os_tick (
      .clk     (clk),
      .rst     (rst),
      .os_tick (os_tick)
   );

   // Two flops resolve metastability; rx_d is only the edge-detect history.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign fall = rx_d & ~rx_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sc        <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (fall) begin
                  sc      <= '0;
                  rx_busy <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               if (os_tick) begin
                  if (sc == SC_HALF) begin
                     // A start bit that is high again at its centre was a glitch.
                     if (rx_s) begin
                        rx_busy <= 1'b0;
                        state   <= IDLE;
                     end else begin
                        sc      <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                     end
                  end else begin
                     sc <= sc + 1'b1;
                  end
               end
            end
            DATA: begin
               if (os_tick) begin
                  if (sc == SC_LAST) begin
                     // Shift right so the first (LSB) bit ends at bit 0.
                     shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                     sc      <= '0;
                     bit_idx <= bit_idx + 1'b1;
                     if (bit_idx == BI_LAST) begin
                        state <= STOP;
                     end
                  end else begin
                     sc <= sc + 1'b1;
                  end
               end
            end
            STOP: begin
               if (os_tick) begin
                  if (sc == SC_LAST) begin
                     if (rx_s) begin
                        rx_data <= shreg;
                        rx_done <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                     sc      <= '0;
                     rx_busy <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     sc <= sc + 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx: a frame-level model queues the
// expected outcome of every frame sent and a monitor scores each output pulse.
module tb_uart_rx;

   localparam int unsigned BIT_CLK = 160;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_busy;
   logic       frame_err;

   uart_rx #(
      .SYS_CLK    (1600),
      .BAUD       (10),
      .OVERSAMPLE (16),
      .DATA_BITS  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .rx_busy   (rx_busy),
      .frame_err (frame_err)
   );

   // Clock / reset
   always #1 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   // Scoreboard state: each entry is {is_framing_error, byte}
   logic [8:0]  exp_q[$];
   logic [7:0]  model_data = 8'h00;
   int unsigned exp_done = 0, exp_err = 0;
   int unsigned done_cnt = 0, err_cnt = 0;
   int unsigned done_cyc[$];
   int unsigned n_checks = 0, n_pass = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Driver tasks (inputs change on the falling edge)
   task automatic idle(input int unsigned n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_ok);
      exp_q.push_back({~stop_ok, d});
      if (stop_ok) exp_done++;
      else         exp_err++;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop_ok);
   endtask

   // Monitor: scores every rx_done / frame_err pulse against the queue
   logic       prev_pulse = 1'b0;
   logic [8:0] mon_e;
   always @(negedge clk) begin
      if (!rst && (rx_done || frame_err)) begin
         check("pulse_exclusive", {31'b0, rx_done & frame_err}, 32'd0);
         check("pulse_width", {31'b0, prev_pulse}, 32'd0);
         check("busy_clear_on_pulse", {31'b0, rx_busy}, 32'd0);
         check("pulse_expected", {31'b0, exp_q.size() > 0}, 32'd1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("pulse_kind", {31'b0, frame_err}, {31'b0, mon_e[8]});
            if (!mon_e[8]) begin
               model_data = mon_e[7:0];
               check("rx_data", {24'b0, rx_data}, {24'b0, mon_e[7:0]});
            end else begin
               check("rx_data_hold_on_err", {24'b0, rx_data}, {24'b0, model_data});
            end
         end
         if (rx_done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
         end
         if (frame_err) err_cnt++;
      end
      prev_pulse = rx_done | frame_err;
   end

   // Directed steps followed by randomized frames
   int unsigned t, gap, seen_busy;
   logic [7:0]  rd;
   logic        rok;
   logic [7:0]  abort_byte;

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_rx_data", {24'b0, rx_data}, 32'd0);
      check("reset_rx_done", {31'b0, rx_done}, 32'd0);
      check("reset_frame_err", {31'b0, frame_err}, 32'd0);
      check("reset_rx_busy", {31'b0, rx_busy}, 32'd0);
      rst = 1'b0;
      idle(50);

      // Single good frame
      send_frame(8'hA5, 1'b1);
      idle(100);
      check("s1_done_cnt", done_cnt, exp_done);
      check("s1_err_cnt", err_cnt, 32'd0);
      check("s1_rx_data", {24'b0, rx_data}, 32'h0000_00A5);
      check("s1_busy_low", {31'b0, rx_busy}, 32'd0);

      // Bad stop bit keeps the previous byte
      send_frame(8'h3C, 1'b0);
      idle(100);
      check("s4_err_cnt", err_cnt, exp_err);
      check("s4_done_cnt", done_cnt, exp_done);
      check("s4_rx_data_kept", {24'b0, rx_data}, 32'h0000_00A5);

      // Back-to-back frames with no idle gap
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(100);
      check("s2_done_cnt", done_cnt, exp_done);
      if (done_cyc.size() >= 2) begin
         gap = done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2];
         check("s2_pulse_gap", {31'b0, (gap >= 1590) && (gap <= 1610)}, 32'd1);
      end
      check("s2_rx_data", {24'b0, rx_data}, 32'h0000_00FF);

      // Glitch shorter than half a bit
      seen_busy = 0;
      rx = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rx_busy) seen_busy = 1;
      end
      rx = 1'b1;
      t = 40;
      while (rx_busy && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("s3_busy_seen", seen_busy, 32'd1);
      check("s3_busy_clear_lt100", {31'b0, t < 100}, 32'd1);
      idle(400);
      check("s3_no_done", done_cnt, exp_done);
      check("s3_no_err", err_cnt, exp_err);

      // Reset during data bit 4 of 0x5A abandons the frame
      abort_byte = 8'h5A;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
      rx = abort_byte[4];
      repeat (BIT_CLK / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_data = 8'h00;
      check("s5_busy_after_rst", {31'b0, rx_busy}, 32'd0);
      check("s5_data_after_rst", {24'b0, rx_data}, 32'd0);
      idle(1800);
      check("s5_no_done", done_cnt, exp_done);
      check("s5_no_err", err_cnt, exp_err);
      send_frame(8'h81, 1'b1);
      idle(100);
      check("s5_rx_data", {24'b0, rx_data}, 32'h0000_0081);
      check("s5_done_cnt", done_cnt, exp_done);

      // Line held low after a framing error
      send_frame(8'($urandom_range(0, 255)), 1'b0);
      rx = 1'b0;
      repeat (3000) @(negedge clk);
      check("s6_err_cnt", err_cnt, exp_err);
      check("s6_no_done_low", done_cnt, exp_done);
      idle(200);
      send_frame(8'h7E, 1'b1);
      idle(100);
      check("s6_rx_data", {24'b0, rx_data}, 32'h0000_007E);
      check("s6_done_cnt", done_cnt, exp_done);

      // Randomized frames, random stop validity and gaps
      for (int k = 0; k < 8; k++) begin
         rd  = 8'($urandom_range(0, 255));
         rok = ($urandom_range(0, 4) != 0);
         send_frame(rd, rok);
         idle(rok ? $urandom_range(0, 40) : $urandom_range(20, 60));
      end
      idle(200);
      check("rand_done_cnt", done_cnt, exp_done);
      check("rand_err_cnt", err_cnt, exp_err);
      check("rand_rx_data", {24'b0, rx_data}, {24'b0, model_data});
      check("queue_drained", exp_q.size(), 32'd0);

      // Final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
